// File: rtl/pnr_peak_capture.sv
// Peak-hold capture of PNR pulse heights over a programmable window, with valid/ready output.
// Optional baseline subtraction is enabled by defining PNR_PEAK_BASELINE_EN.
module pnr_peak_capture #(
  parameter int ADC_W = 14,
  parameter int WIN_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             ADC_CLK,
  input  logic             rstn_i,
  input  logic [ADC_W-1:0] adc_sig,
  input  logic             trigger,
  input  logic             delayed_trigger,
  input  logic [WIN_W-1:0] window_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ADC_W-1:0] peak_value,
  output logic [CNT_W-1:0] event_idx,
  output logic [15:0]      drop_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WINDOW,
    S_PRESENT
  } state_t;

  state_t           state_q, state_d;
  logic [ADC_W-1:0] peak_q;
  logic [WIN_W-1:0] remaining_q;
  logic [CNT_W-1:0] event_cnt_q;
  logic [ADC_W-1:0] peak_result;
  logic             start_window;
  logic             drop_pulse;
  logic             enter_present;
  logic             transfer;

  assign transfer      = (state_q == S_PRESENT) && out_ready;
  assign start_window  = delayed_trigger && ((state_q == S_IDLE) || transfer);
  assign drop_pulse    = delayed_trigger && !start_window;
  assign enter_present = (state_q == S_WINDOW) && (remaining_q == '0);

  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (delayed_trigger) state_d = S_WINDOW;
      S_WINDOW:  if (remaining_q == '0) state_d = S_PRESENT;
      S_PRESENT: if (out_ready) state_d = delayed_trigger ? S_WINDOW : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

`ifdef PNR_PEAK_BASELINE_EN
  logic [ADC_W-1:0] baseline_q;

  // Baseline is taken at the undelayed trigger so it precedes the pulse itself.
  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i)                          baseline_q <= '0;
    else if (trigger && state_q == S_IDLE) baseline_q <= adc_sig;
  end

  assign peak_result = (peak_q >= baseline_q) ? (peak_q - baseline_q) : '0;
`else
  logic unused_trigger;
  assign unused_trigger = trigger;
  assign peak_result    = peak_q;
`endif

  // The trigger-cycle sample is the first of the window; the remaining==0 cycle only hands off.
  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i) begin
      peak_q      <= '0;
      remaining_q <= '0;
      event_cnt_q <= '0;
    end else if (start_window) begin
      peak_q      <= adc_sig;
      remaining_q <= (window_len == '0) ? '0 : window_len - WIN_W'(1);
      event_cnt_q <= event_cnt_q + CNT_W'(1);
    end else if (state_q == S_WINDOW && remaining_q != '0) begin
      if (adc_sig > peak_q) peak_q <= adc_sig;
      remaining_q <= remaining_q - WIN_W'(1);
    end
  end

  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i) begin
      peak_value <= '0;
      event_idx  <= '0;
    end else if (enter_present) begin
      peak_value <= peak_result;
      event_idx  <= event_cnt_q;
    end
  end

  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i)                             drop_cnt <= '0;
    else if (drop_pulse && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end

  assign out_valid = (state_q == S_PRESENT);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pnr_peak_capture.sv
// Directed self-checking bench for pnr_peak_capture; baseline steps run only when
// PNR_PEAK_BASELINE_EN is defined.
module tb_pnr_peak_capture;

  logic        ADC_CLK;
  logic        rstn_i;
  logic [13:0] adc_sig;
  logic        trigger;
  logic        delayed_trigger;
  logic [15:0] window_len;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] peak_value;
  logic [31:0] event_idx;
  logic [15:0] drop_cnt;
  logic        busy;

  int checks;
  int failures;

  pnr_peak_capture #(.ADC_W(14), .WIN_W(16), .CNT_W(32)) dut (
    .ADC_CLK         (ADC_CLK),
    .rstn_i          (rstn_i),
    .adc_sig         (adc_sig),
    .trigger         (trigger),
    .delayed_trigger (delayed_trigger),
    .window_len      (window_len),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .peak_value      (peak_value),
    .event_idx       (event_idx),
    .drop_cnt        (drop_cnt),
    .busy            (busy)
  );

  initial ADC_CLK = 1'b0;
  always #4 ADC_CLK = ~ADC_CLK;

  // Drive one cycle of inputs, then land 1 time unit after the edge that samples them.
  task automatic apply_stimulus(input logic dt, input logic trg, input logic [13:0] adc,
                                input logic [15:0] wl, input logic rdy);
    delayed_trigger = dt;
    trigger         = trg;
    adc_sig         = adc;
    window_len      = wl;
    out_ready       = rdy;
    @(posedge ADC_CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_output({tag, "_peak"},  32'(peak_value), 32'd0);
    check_output({tag, "_idx"},   event_idx, 32'd0);
    check_output({tag, "_drop"},  32'(drop_cnt), 32'd0);
    check_output({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rstn_i          = 1'b0;
    adc_sig         = '0;
    trigger         = 1'b0;
    delayed_trigger = 1'b0;
    window_len      = '0;
    out_ready       = 1'b0;

    apply_stimulus(1'b1, 1'b0, 14'd1234, 16'd4, 1'b1);
    apply_stimulus(1'b0, 1'b0, 14'd0, 16'd4, 1'b1);
    check_all_zero("reset");
    rstn_i = 1'b1;
    apply_stimulus(1'b0, 1'b0, 14'd0, 16'd4, 1'b1);

    $display("[TB] basic window");
    apply_stimulus(1'b1, 1'b0, 14'd4000, 16'd4, 1'b1);
    check_output("basic_busy_rise", 32'(busy), 32'd1);
    check_output("basic_valid_early0", 32'(out_valid), 32'd0);
    apply_stimulus(1'b0, 1'b0, 14'd4100, 16'd4, 1'b1);
    apply_stimulus(1'b0, 1'b0, 14'd4300, 16'd4, 1'b1);
    apply_stimulus(1'b0, 1'b0, 14'd4200, 16'd4, 1'b1);
    check_output("basic_valid_early3", 32'(out_valid), 32'd0);
    check_output("basic_peak_held", 32'(peak_value), 32'd0);
    apply_stimulus(1'b0, 1'b0, 14'd4500, 16'd4, 1'b1);
    check_output("basic_valid", 32'(out_valid), 32'd1);
    check_output("basic_peak", 32'(peak_value), 32'd4300);
    check_output("basic_idx", event_idx, 32'd1);
    apply_stimulus(1'b0, 1'b0, 14'd0, 16'd4, 1'b1);
    check_output("basic_valid_fall", 32'(out_valid), 32'd0);
    check_output("basic_busy_fall", 32'(busy), 32'd0);

    $display("[TB] zero-length window");
    apply_stimulus(1'b1, 1'b0, 14'd5000, 16'd0, 1'b1);
    check_output("zero_valid_early", 32'(out_valid), 32'd0);
    apply_stimulus(1'b0, 1'b0, 14'd6000, 16'd0, 1'b1);
    check_output("zero_valid", 32'(out_valid), 32'd1);
    check_output("zero_peak", 32'(peak_value), 32'd5000);
    check_output("zero_idx", event_idx, 32'd2);
    apply_stimulus(1'b0, 1'b0, 14'd0, 16'd0, 1'b1);
    check_output("zero_done", 32'(out_valid), 32'd0);

    $display("[TB] backpressure and drops");
    apply_stimulus(1'b1, 1'b0, 14'd100, 16'd2, 1'b0);
    apply_stimulus(1'b0, 1'b0, 14'd300, 16'd2, 1'b0);
    apply_stimulus(1'b0, 1'b0, 14'd50, 16'd2, 1'b0);
    check_output("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 50; i++) begin
      apply_stimulus((i == 5 || i == 20 || i == 35), 1'b0, 14'(16383 - i * 7), 16'd9, 1'b0);
      check_output("bp_hold_valid", 32'(out_valid), 32'd1);
      check_output("bp_hold_peak", 32'(peak_value), 32'd300);
      check_output("bp_hold_idx", event_idx, 32'd3);
    end
    check_output("bp_drop", 32'(drop_cnt), 32'd3);

    $display("[TB] back-to-back");
    apply_stimulus(1'b1, 1'b0, 14'd1000, 16'd3, 1'b1);
    check_output("b2b_valid_fall", 32'(out_valid), 32'd0);
    check_output("b2b_busy", 32'(busy), 32'd1);
    check_output("b2b_drop", 32'(drop_cnt), 32'd3);
    apply_stimulus(1'b0, 1'b0, 14'd1200, 16'd3, 1'b1);
    apply_stimulus(1'b0, 1'b0, 14'd1100, 16'd3, 1'b1);
    apply_stimulus(1'b0, 1'b0, 14'd2000, 16'd3, 1'b1);
    check_output("b2b_valid", 32'(out_valid), 32'd1);
    check_output("b2b_peak", 32'(peak_value), 32'd1200);
    check_output("b2b_idx", event_idx, 32'd4);
    apply_stimulus(1'b0, 1'b0, 14'd0, 16'd3, 1'b1);
    check_output("b2b_idle", 32'(busy), 32'd0);

    $display("[TB] drop inside window");
    apply_stimulus(1'b1, 1'b0, 14'd10, 16'd3, 1'b1);
    apply_stimulus(1'b1, 1'b0, 14'd20, 16'd3, 1'b1);
    check_output("win_drop", 32'(drop_cnt), 32'd4);
    apply_stimulus(1'b0, 1'b0, 14'd5, 16'd3, 1'b1);
    apply_stimulus(1'b0, 1'b0, 14'd9999, 16'd3, 1'b1);
    check_output("win_peak", 32'(peak_value), 32'd20);
    check_output("win_idx", event_idx, 32'd5);
    apply_stimulus(1'b0, 1'b0, 14'd0, 16'd3, 1'b1);

`ifdef PNR_PEAK_BASELINE_EN
    $display("[TB] baseline mode");
    apply_stimulus(1'b0, 1'b1, 14'd4000, 16'd2, 1'b1);
    apply_stimulus(1'b1, 1'b0, 14'd4600, 16'd2, 1'b1);
    apply_stimulus(1'b0, 1'b1, 14'd4500, 16'd2, 1'b1);
    apply_stimulus(1'b0, 1'b0, 14'd0, 16'd2, 1'b1);
    check_output("base_peak", 32'(peak_value), 32'd600);
    check_output("base_idx", event_idx, 32'd6);
    apply_stimulus(1'b0, 1'b0, 14'd0, 16'd2, 1'b1);
    apply_stimulus(1'b0, 1'b1, 14'd4000, 16'd1, 1'b1);
    apply_stimulus(1'b1, 1'b0, 14'd3900, 16'd1, 1'b1);
    apply_stimulus(1'b0, 1'b0, 14'd0, 16'd1, 1'b1);
    check_output("base_floor", 32'(peak_value), 32'd0);
    check_output("base_idx2", event_idx, 32'd7);
    apply_stimulus(1'b0, 1'b0, 14'd0, 16'd1, 1'b1);
`endif

    $display("[TB] reset mid-window");
    apply_stimulus(1'b1, 1'b0, 14'd3000, 16'd8, 1'b1);
    apply_stimulus(1'b0, 1'b0, 14'd3500, 16'd8, 1'b1);
    check_output("rst_busy_before", 32'(busy), 32'd1);
    rstn_i = 1'b0;
    #1;
    check_all_zero("rst_async");
    apply_stimulus(1'b0, 1'b0, 14'd3600, 16'd8, 1'b1);
    rstn_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'b0, 14'd3700, 16'd8, 1'b1);
      check_output("rst_no_valid", 32'(out_valid), 32'd0);
    end
    apply_stimulus(1'b1, 1'b0, 14'd777, 16'd1, 1'b1);
    apply_stimulus(1'b0, 1'b0, 14'd0, 16'd1, 1'b1);
    check_output("rst_next_valid", 32'(out_valid), 32'd1);
    check_output("rst_next_peak", 32'(peak_value), 32'd777);
    check_output("rst_next_idx", event_idx, 32'd1);
    apply_stimulus(1'b0, 1'b0, 14'd0, 16'd1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pnr_peak_capture.md
# pnr_peak_capture

Captures the pulse height of each photon-number-resolving (PNR) event from the 14-bit ADC stream. A window opens on the delayed trigger produced by the PNR trigger logic, and the block keeps the maximum sample seen over a programmable number of cycles. The result is presented with an event index on a valid/ready interface to the readout/histogram stage. It sits directly downstream of the PNR delayed trigger, in the ADC clock domain.

## Interface
Parameters:
- `ADC_W`, 14: ADC sample width, unsigned.
- `WIN_W`, 16: width of `window_len`.
- `CNT_W`, 32: width of `event_idx`.

Ports:
- `ADC_CLK` in 1: ADC clock, 125 MHz. This is the only clock.
- `rstn_i` in 1: reset, asynchronous and active-low.
- `adc_sig` in ADC_W: ADC sample, unsigned, the same signal that feeds the trigger.
- `trigger` in 1: undelayed trigger pulse, one cycle wide.
- `delayed_trigger` in 1: delayed trigger pulse, one cycle wide. It opens the window.
- `window_len` in WIN_W: window length in cycles. Sampled at window start.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer ready.
- `peak_value` out ADC_W: peak (or baseline-corrected peak) of the window.
- `event_idx` out CNT_W: index of the accepted event.
- `drop_cnt` out 16: number of delayed triggers rejected while busy. Saturates.
- `busy` out 1: high in the WINDOW and PRESENT states.

## Operation
- The state machine has three states: IDLE, WINDOW, PRESENT.
- IDLE + `delayed_trigger`:
  - go to WINDOW;
  - `peak` ← `adc_sig`;
  - `remaining` ← max(`window_len`, 1) − 1;
  - `event_idx_r` ← `event_idx_r` + 1, wrapping modulo 2^CNT_W.
- WINDOW, each cycle:
  - if `adc_sig` > `peak` (unsigned compare), `peak` ← `adc_sig`;
  - if `remaining` == 0, go to PRESENT; otherwise decrement `remaining`.
- The window covers exactly max(`window_len`, 1) samples. The sample in the `delayed_trigger` cycle is the first. `window_len` = 0 behaves as 1.
- PRESENT: hold `out_valid` = 1 and keep all outputs stable until `out_ready` = 1 at a clock edge. That edge completes the transfer.
- Transfer with no `delayed_trigger` in the same cycle → IDLE.
- Transfer and `delayed_trigger` in the same cycle → WINDOW directly, as from IDLE. The new event is not dropped.
- `delayed_trigger` in WINDOW, or in PRESENT without a transfer:
  - the pulse is ignored;
  - `drop_cnt` increments, saturating at 16'hFFFF;
  - `event_idx` does not advance.
- `trigger` has no effect unless PNR_PEAK_BASELINE_EN is defined (see Configuration).
- The first accepted event after reset reports `event_idx` = 1.

## Timing
- Reset values: `out_valid` = 0, `peak_value` = 0, `event_idx` = 0, `drop_cnt` = 0, `busy` = 0, state = IDLE. The baseline register also resets to 0.
- Assertion of `rstn_i` mid-window or mid-present aborts the event immediately. No result is produced for it.
- `delayed_trigger` is sampled at edge N. With L = max(`window_len`, 1), the window covers the samples at edges N … N+L−1.
- `out_valid` rises after edge N+L, i.e. L cycles of latency from the trigger edge.
- `busy` rises after edge N and falls after the transfer edge, unless a new window starts on that same edge.
- `peak_value` and `event_idx` are registered outputs. They change only on the edge that enters PRESENT.
- Maximum event rate is one event per L+1 cycles, assuming `out_ready` is held high.

## Configuration
- `PNR_PEAK_BASELINE_EN` defined:
  - `baseline` ← `adc_sig` on every `trigger` pulse while in IDLE (taken at the undelayed trigger, before the pulse arrives at the window);
  - on entry to PRESENT, `peak_value` ← `peak` − `baseline` if `peak` ≥ `baseline`, else 0;
  - `trigger` pulses in WINDOW or PRESENT leave `baseline` unchanged.
- `PNR_PEAK_BASELINE_EN` undefined:
  - `peak_value` ← raw `peak`;
  - `trigger` is unused, and no baseline register is built.

## Test plan
- **Basic window.** Ramp `adc_sig` 4000, 4100, 4300, 4200; `window_len` = 4; `delayed_trigger` at cycle 10; `out_ready` = 1 → `out_valid` high for one cycle after edge 14, `peak_value` = 4300, `event_idx` = 1.
- **Zero-length window.** `window_len` = 0, `adc_sig` = 5000 at the trigger cycle → `peak_value` = 5000, `out_valid` one cycle after the trigger edge.
- **Backpressure and drops.** `out_ready` = 0 for 50 cycles after `out_valid`, with 3 extra `delayed_trigger` pulses during that time → outputs stable throughout, `drop_cnt` = 3, `event_idx` still 1. After `out_ready` = 1 → one transfer.
- **Back-to-back.** `delayed_trigger` in the same cycle as the transfer → new window starts, `event_idx` = 2, `drop_cnt` unchanged.
- **Baseline mode.** With `PNR_PEAK_BASELINE_EN`: `trigger` with `adc_sig` = 4000, window peak 4600 → `peak_value` = 600. A second event with baseline 4000 and peak 3900 → `peak_value` = 0.
- **Reset mid-window.** Drive `rstn_i` low 2 cycles into an L = 8 window → all outputs 0 and state IDLE. No `out_valid` for that event, and the next event reports `event_idx` = 1.
